pc_irq_ctrl: RTL and testbench
==============================

PC_IRQ_CTRL -- requirements
Module: pc_irq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, PC/address width.
REQ-002 SHALL have parameter NUM_INT, default 8, interrupt channel count (1..16).
REQ-003 SHALL have parameter ID_W, default 4, irq_id width (2^ID_W >= NUM_INT).
REQ-004 SHALL have parameter PC_START, default 27'hC02422, reset PC and ROM lockout bound.
REQ-005 SHALL have parameter VEC_BASE, default 0, vector base; channel i vectors to VEC_BASE+i+1.
REQ-006 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-007 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port advance  in  1  one-cycle strobe, instruction retired, PC updates.
REQ-009 SHALL have port jump  in  1  retiring instruction is a jump.
REQ-010 SHALL have port offset  in  1  jump is PC-relative.
REQ-011 SHALL have port jump_addr  in  ADDR_W  absolute target or relative offset.
REQ-012 SHALL have port reti  in  1  retiring instruction is return-from-interrupt.
REQ-013 SHALL have port irq_in  in  NUM_INT  level interrupt lines, rising-edge sensitive.
REQ-014 SHALL have port ei / di  in  1 each  global interrupt enable set / clear.
REQ-015 SHALL have port mask_we, mask_wdata  in  1, NUM_INT  channel mask write.
REQ-016 SHALL have port pc_out  out  ADDR_W  current PC.
REQ-017 SHALL have port in_isr  out  1  servicing an interrupt.
REQ-018 SHALL have port irq_ack, irq_id  out  1, ID_W  one-cycle take pulse and taken channel.
REQ-019 SHALL have port pending  out  NUM_INT  latched unserviced edges.

Function
REQ-020 Edge detect: irq_in registered every cycle; irq_in[i] & ~prev[i] sets pending[i], regardless of mask, gie or in_isr.
REQ-021 pending[i] cleared only on take of channel i; a new edge in the same cycle as the take leaves pending[i]=1.
REQ-022 mask_we loads mask<=mask_wdata the next cycle; the mask gates taking only, never latching.
REQ-023 gie: di clears, ei sets, di wins if both high; it is independent of in_isr.
REQ-024 Take condition at an advance cycle: gie & ~in_isr & |(pending & mask) & pc_out < PC_START (ROM code is never interrupted).
REQ-025 Priority: lowest-index eligible channel wins.
REQ-026 next_pc = jump ? (offset ? pc_out+jump_addr : jump_addr) : pc_out+1, all modulo 2^ADDR_W.
REQ-027 At advance, precedence is: reti with in_isr=1, then take, then next_pc.
REQ-028 reti with in_isr=1: pc_out<=backup, in_isr<=0; no take evaluated that cycle.
REQ-029 reti with in_isr=0 is treated as an ordinary instruction (next_pc).
REQ-030 Take: backup<=next_pc, pc_out<=VEC_BASE+id+1, in_isr<=1, pending[id]<=0, irq_ack=1 and irq_id=id for exactly the following cycle.
REQ-031 advance=0: pc_out, backup and in_isr hold; edge latching continues.
REQ-032 irq_ack is 0 except the one cycle after a take; irq_id holds the last taken id.
REQ-033 Nesting is not supported: edges during an ISR stay pending and are eligible at the first advance after reti.

Reset
REQ-034 reset SHALL set pc_out=PC_START, backup=0, in_isr=0, gie=1, mask=all ones, pending=0, edge-detect registers=0, irq_ack=0, irq_id=0.
REQ-035 reset SHALL override all other inputs in the same cycle, including mid-ISR; irq_in held high through reset SHALL NOT produce an edge after reset.

Verification
REQ-036 pc_out=0x10, advance, no jump/irq -> pc_out=0x11; advance with jump, offset=1, jump_addr=0x7FFFFFF -> pc_out=0x10.
REQ-037 pc_out=0x20, pulse irq_in[3] and irq_in[1], advance -> pc_out=VEC_BASE+2, irq_ack=1 with irq_id=1 for one cycle, pending=0x08.
REQ-038 Run REQ-037 then advance with reti -> pc_out=0x21, in_isr=0; next advance -> pc_out=VEC_BASE+4 (channel 3).
REQ-039 mask=0xFE, edge on ch0, advance -> no take, pending[0]=1; write mask=0xFF, advance -> take ch0.
REQ-040 pc_out=PC_START, pending=0x01, advance -> pc_out=PC_START+1, no take.
REQ-041 Assert reset while in_isr=1 with pending=0xFF -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/pc_irq_ctrl.sv
// pc_irq_ctrl: program counter sequencer with a non-nesting interrupt controller.
//
// Behaviour
//   - The PC updates only on an `advance` strobe (one instruction retired).
//     The next PC is pc+1, an absolute jump, or a PC-relative jump.
//   - Rising edges on the irq_in lines are latched into `pending`. Latching
//     happens every cycle and ignores the mask, gie and in_isr.
//   - At an advance, the lowest-index pending, unmasked channel is taken when
//     all of these hold:
//       gie is set, no ISR is active, and pc_out < PC_START.
//     Code at or above PC_START (ROM) is never interrupted.
//   - On a take, the would-be next PC is saved in a single backup register and
//     the PC jumps to VEC_BASE+id+1. A reti restores the saved PC.
//
// Ports
//   clk, reset              clock (rising edge); synchronous active-high reset
//   advance                 instruction-retired strobe
//   jump, offset, jump_addr jump control; offset selects PC-relative
//   reti                    retiring instruction is return-from-interrupt
//   irq_in[NUM_INT]         level interrupt lines (rising-edge sensitive)
//   ei, di                  global interrupt enable set / clear (di wins)
//   mask_we, mask_wdata     channel mask write
//   pc_out                  current PC
//   in_isr                  interrupt service in progress
//   irq_ack, irq_id         one-cycle take pulse and last taken channel
//   pending                 latched, unserviced edges
module pc_irq_ctrl #(
  parameter int                 ADDR_W   = 27,
  parameter int                 NUM_INT  = 8,
  parameter int                 ID_W     = 4,
  parameter logic [ADDR_W-1:0]  PC_START = 27'hC02422,
  parameter logic [ADDR_W-1:0]  VEC_BASE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  input  logic               jump,
  input  logic               offset,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               reti,
  input  logic [NUM_INT-1:0] irq_in,
  input  logic               ei,
  input  logic               di,
  input  logic               mask_we,
  input  logic [NUM_INT-1:0] mask_wdata,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               in_isr,
  output logic               irq_ack,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_INT-1:0] pending
);

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_backup;
  logic               r_in_isr;
  logic               r_gie;
  logic [NUM_INT-1:0] r_mask;
  logic [NUM_INT-1:0] r_pending;
  logic [NUM_INT-1:0] r_prev;
  logic               r_armed;
  logic               r_ack;
  logic [ID_W-1:0]    r_id;

  logic [NUM_INT-1:0] w_edge;
  logic [NUM_INT-1:0] w_elig;
  logic [NUM_INT-1:0] w_clr;
  logic [ID_W-1:0]    w_id;
  logic               w_any;
  logic               w_ret;
  logic               w_take;
  logic [ADDR_W-1:0]  w_next_pc;
  logic [ADDR_W-1:0]  w_vec;

  // The edge-detect history resets to zero. The first cycle after reset only
  // loads the history and does not latch edges. Otherwise a line held high
  // through reset would look like a fresh edge once reset drops.
  assign w_edge = r_armed ? (irq_in & ~r_prev) : '0;
  assign w_elig = r_pending & r_mask;
  assign w_any  = |w_elig;

  // Lowest index wins: scan from the top so that lower indices overwrite.
  always_comb begin
    w_id = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (w_elig[i]) w_id = ID_W'(i);
    end
  end

  assign w_next_pc = jump ? (offset ? r_pc + jump_addr : jump_addr)
                          : r_pc + ADDR_W'(1);

  // A reti inside an ISR pre-empts any take in that cycle.
  assign w_ret  = advance & reti & r_in_isr;
  assign w_take = advance & ~w_ret & r_gie & ~r_in_isr & w_any & (r_pc < PC_START);
  assign w_vec  = VEC_BASE + ADDR_W'(w_id) + ADDR_W'(1);
  assign w_clr  = w_take ? (NUM_INT'(1) << w_id) : '0;

  // Per-channel pending bit. A new edge in the same cycle as the take wins
  // over the clear, so that edge is not lost.
  for (genvar g = 0; g < NUM_INT; g++) begin : g_pend
    always_ff @(posedge clk) begin
      if (reset)          r_pending[g] <= 1'b0;
      else if (w_edge[g]) r_pending[g] <= 1'b1;
      else if (w_clr[g])  r_pending[g] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev  <= '0;
      r_armed <= 1'b0;
      r_mask  <= '1;
      r_gie   <= 1'b1;
    end else begin
      r_prev  <= irq_in;
      r_armed <= 1'b1;
      if (mask_we) r_mask <= mask_wdata;
      if (di)      r_gie  <= 1'b0;
      else if (ei) r_gie  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= PC_START;
      r_backup <= '0;
      r_in_isr <= 1'b0;
      r_ack    <= 1'b0;
      r_id     <= '0;
    end else begin
      r_ack <= w_take;
      if (w_ret) begin
        r_pc     <= r_backup;
        r_in_isr <= 1'b0;
      end else if (w_take) begin
        r_backup <= w_next_pc;
        r_pc     <= w_vec;
        r_in_isr <= 1'b1;
        r_id     <= w_id;
      end else if (advance) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign pc_out  = r_pc;
  assign in_isr  = r_in_isr;
  assign irq_ack = r_ack;
  assign irq_id  = r_id;
  assign pending = r_pending;

endmodule

// File: tb/tb_pc_irq_ctrl.sv
// Scoreboard bench for pc_irq_ctrl. Stimulus pushes hand-computed expected
// state after every advance/reset cycle and expected ids for every take. The
// monitor pops and compares when the DUT presents a result.
module tb_pc_irq_ctrl;
  localparam int ADDR_W = 27;
  localparam int NI     = 8;
  localparam int IW     = 4;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              isr;
    logic              ack;
    logic [IW-1:0]     id;
    logic [NI-1:0]     pend;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, advance, jump, offset, reti, ei, di, mask_we;
  logic [ADDR_W-1:0] jump_addr;
  logic [NI-1:0]     irq_in, mask_wdata;
  logic [ADDR_W-1:0] pc_out;
  logic              in_isr, irq_ack;
  logic [IW-1:0]     irq_id;
  logic [NI-1:0]     pending;

  exp_t          sq[$];
  logic [IW-1:0] aq[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          chk_d   = 1'b0;

  pc_irq_ctrl dut (
    .clk(clk), .reset(reset), .advance(advance), .jump(jump), .offset(offset),
    .jump_addr(jump_addr), .reti(reti), .irq_in(irq_in), .ei(ei), .di(di),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .pc_out(pc_out),
    .in_isr(in_isr), .irq_ack(irq_ack), .irq_id(irq_id), .pending(pending)
  );

  always #5 clk = ~clk;

  // DUT outputs are valid the cycle after an advance or reset.
  always @(posedge clk) chk_d <= advance | reset;

  always @(negedge clk) begin
    exp_t e;
    logic [IW-1:0] ei_id;
    if (chk_d) begin
      n_tests++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL state_unexpected: no expectation queued, pc=%h", pc_out);
      end else begin
        e = sq.pop_front();
        if (pc_out !== e.pc || in_isr !== e.isr || irq_ack !== e.ack ||
            irq_id !== e.id || pending !== e.pend) begin
          n_fail++;
          $display("FAIL state: got pc=%h isr=%b ack=%b id=%0d pend=%h, want pc=%h isr=%b ack=%b id=%0d pend=%h",
                   pc_out, in_isr, irq_ack, irq_id, pending, e.pc, e.isr, e.ack, e.id, e.pend);
        end
      end
    end
    if (irq_ack === 1'b1) begin
      n_tests++;
      if (aq.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: got id=%0d, want no ack", irq_id);
      end else begin
        ei_id = aq.pop_front();
        if (irq_id !== ei_id) begin
          n_fail++;
          $display("FAIL ack_id: got %0d, want %0d", irq_id, ei_id);
        end
      end
    end
  end

  task automatic clr_strobes();
    advance = 0; jump = 0; offset = 0; reti = 0; ei = 0; di = 0; mask_we = 0;
  endtask

  task automatic idle();
    @(negedge clk);
    clr_strobes();
  endtask

  // One advance cycle; jump/reti controls are set by the caller beforehand.
  task automatic adv(input logic [ADDR_W-1:0] pc, input logic isr, input logic ack,
                     input logic [IW-1:0] id, input logic [NI-1:0] pend);
    exp_t e;
    e.pc = pc; e.isr = isr; e.ack = ack; e.id = id; e.pend = pend;
    sq.push_back(e);
    if (ack) aq.push_back(id);
    advance = 1;
    @(negedge clk);
    clr_strobes();
  endtask

  task automatic jmp(input logic [ADDR_W-1:0] a, input logic off);
    jump = 1; offset = off; jump_addr = a;
  endtask

  task automatic do_reset();
    exp_t e;
    e.pc = 27'hC02422; e.isr = 0; e.ack = 0; e.id = 0; e.pend = 0;
    sq.push_back(e);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_strobes();
    reset = 0; jump_addr = '0; mask_wdata = '0;
    irq_in = 8'h80;               // ch7 held high across reset
    do_reset();
    do_reset();
    idle();                       // first post-reset cycle: no edge from ch7

    // PC sequencing and modulo wrap of a relative jump
    jmp(27'h10, 0);       adv(27'h10, 0, 0, 0, 8'h00);
                          adv(27'h11, 0, 0, 0, 8'h00);
    jmp(27'h7FFFFFF, 1);  adv(27'h10, 0, 0, 0, 8'h00);
    jmp(27'h20, 0);       adv(27'h20, 0, 0, 0, 8'h00);

    // Two edges, lower index taken first, the other waits for reti
    irq_in = 8'h8A; idle(); irq_in = 8'h80;
    adv(27'h2, 1, 1, 1, 8'h08);
    adv(27'h3, 1, 0, 1, 8'h08);          // no nesting inside ISR
    reti = 1; adv(27'h21, 0, 0, 1, 8'h08);
    adv(27'h4, 1, 1, 3, 8'h00);
    reti = 1; adv(27'h22, 0, 0, 3, 8'h00);

    // Mask gates taking but not latching
    mask_we = 1; mask_wdata = 8'hFE; idle();
    irq_in = 8'h81; idle(); irq_in = 8'h80;
    adv(27'h23, 0, 0, 3, 8'h01);
    mask_we = 1; mask_wdata = 8'hFF; idle();
    adv(27'h1, 1, 1, 0, 8'h00);
    reti = 1; adv(27'h24, 0, 0, 0, 8'h00);

    // gie: di blocks, di wins over ei, ei re-enables
    di = 1; idle();
    irq_in = 8'h84; idle(); irq_in = 8'h80;
    adv(27'h25, 0, 0, 0, 8'h04);
    ei = 1; di = 1; idle();
    adv(27'h26, 0, 0, 0, 8'h04);
    ei = 1; idle();
    adv(27'h3, 1, 1, 2, 8'h00);
    reti = 1; adv(27'h27, 0, 0, 2, 8'h00);

    // ROM lockout at PC_START, take allowed at PC_START-1
    jmp(27'hC02422, 0); adv(27'hC02422, 0, 0, 2, 8'h00);
    irq_in = 8'h81; idle(); irq_in = 8'h80;
    adv(27'hC02423, 0, 0, 2, 8'h01);
    jmp(27'hC02421, 0); adv(27'hC02421, 0, 0, 2, 8'h01);
    adv(27'h1, 1, 1, 0, 8'h00);

    // Reset mid-ISR with everything pending; line held high across reset
    irq_in = 8'h00; idle();
    irq_in = 8'hFF; idle();
    do_reset();
    idle();
    adv(27'hC02423, 0, 0, 0, 8'h00);

    // Edge in the same cycle as the take keeps the channel pending
    jmp(27'h30, 0); adv(27'h30, 0, 0, 0, 8'h00);
    irq_in = 8'h00; idle();
    irq_in = 8'h01; idle();
    irq_in = 8'h00; idle();
    irq_in = 8'h01; adv(27'h1, 1, 1, 0, 8'h01);
    irq_in = 8'h00;
    reti = 1; adv(27'h31, 0, 0, 0, 8'h01);
    adv(27'h1, 1, 1, 0, 8'h00);
    idle(); idle();

    n_tests++;
    if (sq.size() != 0) begin
      n_fail++;
      $display("FAIL state_queue_drain: got %0d left, want 0", sq.size());
    end
    n_tests++;
    if (aq.size() != 0) begin
      n_fail++;
      $display("FAIL ack_queue_drain: got %0d left, want 0", aq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
